// File: rtl/calc_pkg.sv
// Shared definitions for the calculator datapath: result width, display digit
// count, converter state encoding and the counter-width helper.
package calc_pkg;

  // Width of the arithmetic result and number of BCD digits on the display.
  localparam int RESULT_WIDTH = 16;
  localparam int BCD_DIGITS   = 5;

  // Converter FSM states.
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } conv_state_t;

  // Bits needed to hold an iteration count from 0 up to w inclusive.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

  localparam int CNT_WIDTH = cnt_width(RESULT_WIDTH);

endpackage

// File: rtl/bcd_digit_adjust.sv
// One double-dabble digit correction: adds 3 to a BCD digit that is 5 or more,
// so that the following left shift carries correctly into the next digit.
// Ports:
//   digit_in  - current BCD digit (0..9)
//   digit_out - digit + 3 if digit_in >= 5, else digit_in
module bcd_digit_adjust (
  input  logic [3:0] digit_in,
  output logic [3:0] digit_out
);

  // digit_in <= 9, so digit_in + 3 <= 12 and never leaves 4 bits.
  assign digit_out = (digit_in >= 4'd5) ? (digit_in + 4'd3) : digit_in;

endmodule

// File: rtl/result_bcd_converter.sv
// Iterative binary-to-BCD converter (shift-and-add-3), one bit per clock.
// The last completed result is held on bcd_out between conversions.
// Ports:
//   clock   - system clock, rising edge
//   reset   - synchronous, active-high
//   bin_in  - binary operand, captured when start is accepted
//   start   - request a conversion (only honoured while idle)
//   busy    - conversion in progress (WIDTH cycles)
//   done    - one-cycle pulse when bcd_out has just been updated
//   valid   - at least one conversion has completed since reset
//   bcd_out - packed BCD result, digit 0 (units) in bits [3:0]
module result_bcd_converter
  import calc_pkg::*;
#(
  parameter int WIDTH  = RESULT_WIDTH,
  parameter int DIGITS = BCD_DIGITS
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      bin_in,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  valid,
  output logic [4*DIGITS-1:0]   bcd_out
);

  localparam int SW    = 4 * DIGITS;
  localparam int CNT_W = cnt_width(WIDTH);

  conv_state_t      state_reg, state_next;
  logic [WIDTH-1:0] bin_reg, bin_next;
  logic [SW-1:0]    scratch_reg, scratch_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [SW-1:0]    bcd_reg, bcd_next;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;
  logic             valid_reg, valid_next;

  logic [SW-1:0]    adjusted;
  logic [SW-1:0]    shifted;

  // Add-3 correction on every scratch digit in parallel.
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adjust
      bcd_digit_adjust u_adjust (
        .digit_in  (scratch_reg[4*gi +: 4]),
        .digit_out (adjusted[4*gi +: 4])
      );
    end
  endgenerate

  // Scratch after correction and one left shift; binary MSB enters bit 0.
  assign shifted = {adjusted[SW-2:0], bin_reg[WIDTH-1]};

  always_comb begin
    state_next   = state_reg;
    bin_next     = bin_reg;
    scratch_next = scratch_reg;
    cnt_next     = cnt_reg;
    bcd_next     = bcd_reg;
    busy_next    = busy_reg;
    done_next    = 1'b0;
    valid_next   = valid_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next   = SHIFT;
          bin_next     = bin_in;
          scratch_next = '0;
          cnt_next     = CNT_W'(WIDTH);
          busy_next    = 1'b1;
        end
      end
      SHIFT: begin
        scratch_next = shifted;
        // The bit leaving the top of scratch is always 0 (no overflow), so
        // recirculating it into the spent low end of bin_reg is the same as
        // shifting in a zero.
        bin_next     = {bin_reg[WIDTH-2:0], adjusted[SW-1]};
        cnt_next     = cnt_reg - CNT_W'(1);
        if (cnt_reg == CNT_W'(1)) begin
          bcd_next   = shifted;
          done_next  = 1'b1;
          valid_next = 1'b1;
          busy_next  = 1'b0;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg   <= IDLE;
      bin_reg     <= '0;
      scratch_reg <= '0;
      cnt_reg     <= '0;
      bcd_reg     <= '0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      valid_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      bin_reg     <= bin_next;
      scratch_reg <= scratch_next;
      cnt_reg     <= cnt_next;
      bcd_reg     <= bcd_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
      valid_reg   <= valid_next;
    end
  end

  assign busy    = busy_reg;
  assign done    = done_reg;
  assign valid   = valid_reg;
  assign bcd_out = bcd_reg;

endmodule

// File: tb/tb_result_bcd_converter.sv
// Self-checking bench for result_bcd_converter: table-driven conversions plus
// hand-written sequences for start-while-busy, back-to-back and mid-reset.
module tb_result_bcd_converter;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] bin_in;
  logic        start;
  logic        busy;
  logic        done;
  logic        valid;
  logic [19:0] bcd_out;

  int total  = 0;
  int passed = 0;

  result_bcd_converter dut (
    .clock   (clock),
    .reset   (reset),
    .bin_in  (bin_in),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .valid   (valid),
    .bcd_out (bcd_out)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [15:0] bin;
    logic [19:0] exp;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) begin
      passed++;
      $display("check %-22s got %0h expected %0h ok", name, act, exp);
    end else begin
      $display("FAIL %-22s got %0h expected %0h", name, act, exp);
    end
  endtask

  // Pulse start with operand v, then watch 30 cycles. bin_in is scrambled
  // after capture; bcd_out must keep value hold while busy.
  task automatic run_conv(input logic [15:0] v, input logic [19:0] hold,
                          output int bc, output int dc, output bit stable);
    @(negedge clock);
    bin_in = v;
    start  = 1'b1;
    @(negedge clock);
    start  = 1'b0;
    bin_in = ~v;
    bc = 0;
    dc = 0;
    stable = 1'b1;
    repeat (30) begin
      if (busy) begin
        bc++;
        if (bcd_out !== hold) stable = 1'b0;
      end
      if (done) dc++;
      @(negedge clock);
    end
  endtask

  initial begin
    int          bc, dc;
    bit          stable;
    logic [19:0] last;
    int          t1, t2;
    logic [19:0] r1, r2;

    vecs[0] = '{bin: 16'd1234,  exp: 20'h01234};
    vecs[1] = '{bin: 16'd0,     exp: 20'h00000};
    vecs[2] = '{bin: 16'd65535, exp: 20'h65535};
    vecs[3] = '{bin: 16'd9,     exp: 20'h00009};
    vecs[4] = '{bin: 16'd10,    exp: 20'h00010};

    reset  = 1'b1;
    start  = 1'b0;
    bin_in = '0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    check("reset_busy",  32'(busy),    32'd0);
    check("reset_done",  32'(done),    32'd0);
    check("reset_valid", 32'(valid),   32'd0);
    check("reset_bcd",   32'(bcd_out), 32'h0);

    last = 20'h0;
    for (int i = 0; i < 5; i++) begin
      run_conv(vecs[i].bin, last, bc, dc, stable);
      check($sformatf("v%0d_bcd", i),    32'(bcd_out), 32'(vecs[i].exp));
      check($sformatf("v%0d_busy", i),   32'(bc),      32'd16);
      check($sformatf("v%0d_done", i),   32'(dc),      32'd1);
      check($sformatf("v%0d_valid", i),  32'(valid),   32'd1);
      check($sformatf("v%0d_hold", i),   32'(stable),  32'd1);
      last = vecs[i].exp;
    end

    // Start pulsed again while busy with a different operand.
    @(negedge clock);
    bin_in = 16'd500;
    start  = 1'b1;
    @(negedge clock);
    start = 1'b0;
    bc = 0;
    dc = 0;
    for (int c = 0; c < 30; c++) begin
      if (c == 4) begin
        start  = 1'b1;
        bin_in = 16'd777;
      end else begin
        start = 1'b0;
      end
      if (busy) bc++;
      if (done) dc++;
      @(negedge clock);
    end
    check("busy_start_bcd",  32'(bcd_out), 32'h00500);
    check("busy_start_done", 32'(dc),      32'd1);
    check("busy_start_busy", 32'(bc),      32'd16);

    // Start held high: two conversions, results 17 cycles apart.
    @(negedge clock);
    bin_in = 16'd42;
    start  = 1'b1;
    @(negedge clock);
    bin_in = 16'd99;
    t1 = -1;
    t2 = -1;
    r1 = '0;
    r2 = '0;
    stable = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (done) begin
        if (t1 < 0) begin
          t1 = c;
          r1 = bcd_out;
        end else if (t2 < 0) begin
          t2 = c;
          r2 = bcd_out;
        end
      end else if (t1 >= 0 && t2 < 0 && bcd_out !== 20'h00042) begin
        stable = 1'b0;
      end
      @(negedge clock);
    end
    start = 1'b0;
    repeat (20) @(negedge clock);
    check("b2b_first",  32'(r1),     32'h00042);
    check("b2b_second", 32'(r2),     32'h00099);
    check("b2b_gap",    32'(t2 - t1), 32'd17);
    check("b2b_hold",   32'(stable), 32'd1);

    // Reset in the middle of a conversion.
    run_conv(16'd7, 20'h00099, bc, dc, stable);
    check("pre_rst_bcd", 32'(bcd_out), 32'h00007);
    @(negedge clock);
    bin_in = 16'd4321;
    start  = 1'b1;
    @(negedge clock);
    start = 1'b0;
    dc = 0;
    repeat (7) begin
      if (done) dc++;
      @(negedge clock);
    end
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    repeat (20) begin
      if (done) dc++;
      @(negedge clock);
    end
    check("rst_mid_done",  32'(dc),      32'd0);
    check("rst_mid_busy",  32'(busy),    32'd0);
    check("rst_mid_valid", 32'(valid),   32'd0);
    check("rst_mid_bcd",   32'(bcd_out), 32'h0);

    run_conv(16'd4321, 20'h0, bc, dc, stable);
    check("post_rst_bcd",   32'(bcd_out), 32'h04321);
    check("post_rst_done",  32'(dc),      32'd1);
    check("post_rst_valid", 32'(valid),   32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
